// File: rtl/mlp_layer_sequencer.sv
// ---------------------------------------------------------------------------
// mlp_layer_sequencer
//
// Address/control sequencer for one fully-connected MLP layer. For every
// output neuron it streams the (input, weight) SRAM address pairs with a read
// enable, then re-times the element tags through a read-latency pipeline so
// the MAC receives valid/clear/last strobes aligned with the SRAM data.
// Between neurons it waits for the sigmoid stage (out_ready) before issuing
// the next neuron.
//
// Optional feature: define SEQ_BIAS_EN to append one bias element per neuron
// (in_addr = N_IN, the input SRAM slot holding 1.0). The weight rows then
// have a stride of N_IN+1.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset, aborts a pass without done
//   start      begin a layer pass (only honoured while idle)
//   out_ready  downstream can accept the next neuron result
//   rd_en      SRAM read enable for in_addr / wgt_addr
//   in_addr    input SRAM address (element index)
//   wgt_addr   weight SRAM address
//   mac_valid  SRAM data at the MAC inputs is valid
//   mac_clear  first element of a neuron, MAC loads instead of accumulating
//   mac_last   final element of a neuron
//   neuron_idx neuron number aligned with mac_valid (0 when not valid)
//   busy       high from start acceptance until done
//   done       one-cycle pulse at the end of the pass
// ---------------------------------------------------------------------------
module mlp_layer_sequencer #(
  parameter int N_IN     = 784,
  parameter int N_OUT    = 200,
  parameter int IN_AW    = 10,
  parameter int WGT_AW   = 18,
  parameter int WGT_BASE = 0,
  parameter int RD_LAT   = 1,
  parameter int NIDX_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              out_ready,
  output logic              rd_en,
  output logic [IN_AW-1:0]  in_addr,
  output logic [WGT_AW-1:0] wgt_addr,
  output logic              mac_valid,
  output logic              mac_clear,
  output logic              mac_last,
  output logic [NIDX_W-1:0] neuron_idx,
  output logic              busy,
  output logic              done
);

`ifdef SEQ_BIAS_EN
  localparam int N_ELEM = N_IN + 1;
`else
  localparam int N_ELEM = N_IN;
`endif

  localparam logic [IN_AW-1:0]  LAST_ELEM   = IN_AW'(N_ELEM - 1);
  localparam logic [NIDX_W-1:0] LAST_NEURON = NIDX_W'(N_OUT - 1);
  localparam logic [WGT_AW-1:0] WGT_START   = WGT_AW'(WGT_BASE);
  localparam logic [2:0]        DRAIN_LAST  = 3'(RD_LAT - 1);

  localparam longint WGT_SPAN  = longint'(WGT_BASE) + longint'(N_OUT) * longint'(N_ELEM) - 1;
  localparam longint WGT_LIMIT = longint'(1) << WGT_AW;
  localparam longint IN_SPAN   = longint'(N_ELEM - 1);
  localparam longint IN_LIMIT  = longint'(1) << IN_AW;

  // Configurations whose address ranges do not fit the SRAM address widths
  // would silently wrap, so they are rejected when the design is elaborated.
  if (WGT_SPAN >= WGT_LIMIT) begin : g_wgt_overflow
    $error("mlp_layer_sequencer: weight address range exceeds WGT_AW");
  end
  if (IN_SPAN >= IN_LIMIT) begin : g_in_overflow
    $error("mlp_layer_sequencer: input address range exceeds IN_AW");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, HOLD, DRAIN, DONE} state_e;

  // One read-pipeline entry: the tags that must reach the MAC with the data.
  typedef struct packed {
    logic              v;
    logic              c;
    logic              l;
    logic [NIDX_W-1:0] n;
  } rd_tag_t;

  state_e            state_q, state_d;
  logic [IN_AW-1:0]  elem_q, elem_d;
  logic [NIDX_W-1:0] neuron_q, neuron_d;
  logic [WGT_AW-1:0] wgt_q, wgt_d;
  logic [2:0]        drain_q, drain_d;
  rd_tag_t           pipe_q [RD_LAT];
  rd_tag_t           pipe_d [RD_LAT];

  logic elem_last;
  logic neuron_last;

  assign elem_last   = (elem_q == LAST_ELEM);
  assign neuron_last = (neuron_q == LAST_NEURON);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A neuron boundary either flows straight into the next
  // neuron or parks in HOLD until the sigmoid stage is ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = ISSUE;
      ISSUE: begin
        if (elem_last) begin
          if (neuron_last)     state_d = DRAIN;
          else if (!out_ready) state_d = HOLD;
        end
      end
      HOLD:  if (out_ready) state_d = ISSUE;
      DRAIN: if (drain_q == DRAIN_LAST) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    rd_en = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      ISSUE: begin
        rd_en = 1'b1;
        busy  = 1'b1;
      end
      HOLD, DRAIN: busy = 1'b1;
      DONE:        done = 1'b1;
      default: ;
    endcase
  end

  // Address counters. The weight address simply increments because the
  // weight rows are stored back to back with a stride of N_ELEM; after the
  // last element of a neuron the counters already point at the next neuron's
  // element 0, which is what HOLD presents.
  always_comb begin
    elem_d   = elem_q;
    neuron_d = neuron_q;
    wgt_d    = wgt_q;
    drain_d  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          elem_d   = '0;
          neuron_d = '0;
          wgt_d    = WGT_START;
        end
      end
      ISSUE: begin
        wgt_d = wgt_q + WGT_AW'(1);
        if (elem_last) begin
          elem_d   = '0;
          neuron_d = neuron_q + NIDX_W'(1);
        end else begin
          elem_d = elem_q + IN_AW'(1);
        end
      end
      DRAIN: drain_d = drain_q + 3'd1;
      DONE: begin
        elem_d   = '0;
        neuron_d = '0;
        wgt_d    = '0;
      end
      default: ;
    endcase
  end

  // Read pipeline: tags are gated by rd_en so clear/last/neuron_idx are
  // never seen without mac_valid.
  always_comb begin
    pipe_d[0]   = '0;
    pipe_d[0].v = rd_en;
    pipe_d[0].c = rd_en & (elem_q == '0);
    pipe_d[0].l = rd_en & elem_last;
    pipe_d[0].n = rd_en ? neuron_q : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      elem_q   <= '0;
      neuron_q <= '0;
      wgt_q    <= '0;
      drain_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      elem_q   <= elem_d;
      neuron_q <= neuron_d;
      wgt_q    <= wgt_d;
      drain_q  <= drain_d;
      pipe_q   <= pipe_d;
    end
  end

  assign in_addr    = elem_q;
  assign wgt_addr   = wgt_q;
  assign mac_valid  = pipe_q[RD_LAT-1].v;
  assign mac_clear  = pipe_q[RD_LAT-1].c;
  assign mac_last   = pipe_q[RD_LAT-1].l;
  assign neuron_idx = pipe_q[RD_LAT-1].n;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mlp_layer_sequencer
//
// Drives two sequencer instances (RD_LAT=1 with WGT_BASE=0, RD_LAT=3 with
// WGT_BASE=8) on a 4-input, 3-neuron layer. A behavioural model tracks the
// element count of the pass and a latency queue of issued tags; every cycle
// the outputs of both instances are compared against it. Directed literal
// expectations pin the key cycle numbers of each scenario.
// ---------------------------------------------------------------------------
module tb_mlp_layer_sequencer;

  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
`ifdef SEQ_BIAS_EN
  localparam int N_ELEM       = 5;
  localparam int L_LAST1      = 16;
  localparam int L_DONE1      = 17;
  localparam int L_DONE3      = 19;
  localparam int L_IN5        = 4;
  localparam int L_RD5        = 1;
  localparam int L_HOLD_WGT   = 5;
  localparam int L_HOLD_DONE1 = 19;
`else
  localparam int N_ELEM       = 4;
  localparam int L_LAST1      = 13;
  localparam int L_DONE1      = 14;
  localparam int L_DONE3      = 16;
  localparam int L_IN5        = 0;
  localparam int L_RD5        = 0;
  localparam int L_HOLD_WGT   = 4;
  localparam int L_HOLD_DONE1 = 17;
`endif
  localparam int TOTAL = N_ELEM * N_OUT;

  typedef struct packed {
    logic       v;
    logic       c;
    logic       l;
    logic [3:0] n;
  } tag_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start1, start3;
  logic       out_ready;
  logic       rd_en1, rd_en3;
  logic [3:0] in_addr1, in_addr3;
  logic [5:0] wgt_addr1, wgt_addr3;
  logic       mac_valid1, mac_valid3;
  logic       mac_clear1, mac_clear3;
  logic       mac_last1, mac_last3;
  logic [3:0] nidx1, nidx3;
  logic       busy1, busy3;
  logic       done1, done3;

  int errors = 0;
  int checks = 0;
  int edges  = 0;
  int t0     = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mlp_layer_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .IN_AW(4), .WGT_AW(6),
    .WGT_BASE(0), .RD_LAT(1), .NIDX_W(4)
  ) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .out_ready(out_ready),
    .rd_en(rd_en1), .in_addr(in_addr1), .wgt_addr(wgt_addr1),
    .mac_valid(mac_valid1), .mac_clear(mac_clear1), .mac_last(mac_last1),
    .neuron_idx(nidx1), .busy(busy1), .done(done1)
  );

  mlp_layer_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .IN_AW(4), .WGT_AW(6),
    .WGT_BASE(8), .RD_LAT(3), .NIDX_W(4)
  ) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .out_ready(out_ready),
    .rd_en(rd_en3), .in_addr(in_addr3), .wgt_addr(wgt_addr3),
    .mac_valid(mac_valid3), .mac_clear(mac_clear3), .mac_last(mac_last3),
    .neuron_idx(nidx3), .busy(busy3), .done(done3)
  );

  // Behavioural model: index 0 models u_dut1, index 1 models u_dut3.
  tag_t mp [2][4];
  bit   m_run  [2];
  bit   m_hold [2];
  bit   m_done [2];
  int   m_k    [2];
  tag_t mt, mo;
  bit   mst;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int base_of(input int i);
    return (i == 0) ? 0 : 8;
  endfunction

  function automatic bit m_issuing(input int i);
    return m_run[i] && !m_hold[i] && (m_k[i] < TOTAL);
  endfunction

  // Model update: one element issued per un-held running cycle, issued tags
  // emerge RD_LAT cycles later, and done follows the final neuron's last tag.
  always @(posedge clk) begin
    edges++;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_run[i]  = 1'b0;
        m_hold[i] = 1'b0;
        m_done[i] = 1'b0;
        m_k[i]    = 0;
        for (int j = 0; j < 4; j++) mp[i][j] = '0;
      end else begin
        mo = mp[i][lat_of(i)-1];
        mt = '0;
        if (m_issuing(i)) begin
          mt.v = 1'b1;
          mt.c = (m_k[i] % N_ELEM) == 0;
          mt.l = (m_k[i] % N_ELEM) == N_ELEM - 1;
          mt.n = 4'(m_k[i] / N_ELEM);
        end
        for (int j = 3; j > 0; j--) mp[i][j] = mp[i][j-1];
        mp[i][0] = mt;
        mst = (i == 0) ? start1 : start3;
        if (m_done[i]) begin
          m_done[i] = 1'b0;
        end else if (m_run[i]) begin
          if (m_issuing(i)) begin
            m_k[i]++;
            if ((m_k[i] % N_ELEM) == 0 && m_k[i] < TOTAL && !out_ready) m_hold[i] = 1'b1;
          end else if (m_hold[i] && out_ready) begin
            m_hold[i] = 1'b0;
          end
          if (mo.l && mo.n == 4'(N_OUT - 1)) begin
            m_done[i] = 1'b1;
            m_run[i]  = 1'b0;
          end
        end else if (mst) begin
          m_run[i]  = 1'b1;
          m_k[i]    = 0;
          m_hold[i] = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic compareInst(input int i, input logic rd, input logic bs, input logic dn,
                             input logic v, input logic c, input logic l,
                             input logic [3:0] n, input logic [3:0] ia, input logic [5:0] wa);
    tag_t  e;
    string p;
    p = (i == 0) ? "d1" : "d3";
    e = mp[i][lat_of(i)-1];
    checkOutput({p, ".rd_en"},      32'(rd), 32'(m_issuing(i)));
    checkOutput({p, ".busy"},       32'(bs), 32'(m_run[i]));
    checkOutput({p, ".done"},       32'(dn), 32'(m_done[i]));
    checkOutput({p, ".mac_valid"},  32'(v),  32'(e.v));
    checkOutput({p, ".mac_clear"},  32'(c),  32'(e.c));
    checkOutput({p, ".mac_last"},   32'(l),  32'(e.l));
    checkOutput({p, ".neuron_idx"}, 32'(n),  32'(e.n));
    if (m_issuing(i) || (m_run[i] && m_hold[i])) begin
      checkOutput({p, ".in_addr"},  32'(ia), 32'(m_k[i] % N_ELEM));
      checkOutput({p, ".wgt_addr"}, 32'(wa), 32'((base_of(i) + m_k[i]) % 64));
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      compareInst(0, rd_en1, busy1, done1, mac_valid1, mac_clear1, mac_last1, nidx1, in_addr1, wgt_addr1);
      compareInst(1, rd_en3, busy3, done3, mac_valid3, mac_clear3, mac_last3, nidx3, in_addr3, wgt_addr3);
    end
  end

  function automatic int cycle();
    return edges - t0 + 1;
  endfunction

  task automatic waitCycle(input int n);
    do @(negedge clk); while (cycle() < n);
  endtask

  // Pulse start into both instances; the sampling edge becomes edge 0.
  task automatic applyStimulus();
    @(negedge clk);
    start1 = 1'b1;
    start3 = 1'b1;
    @(posedge clk);
    #1;
    t0     = edges;
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit [10:0] pat;
    int        guard;
    pat       = 11'b10110011101;
    reset     = 1'b1;
    start1    = 1'b0;
    start3    = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst.rd_en1",     32'(rd_en1),     32'd0);
    checkOutput("rst.busy1",      32'(busy1),      32'd0);
    checkOutput("rst.done1",      32'(done1),      32'd0);
    checkOutput("rst.mac_valid1", 32'(mac_valid1), 32'd0);
    checkOutput("rst.wgt_addr1",  32'(wgt_addr1),  32'd0);
    checkOutput("rst.in_addr1",   32'(in_addr1),   32'd0);
    checkOutput("rst.busy3",      32'(busy3),      32'd0);
    checkOutput("rst.mac_valid3", 32'(mac_valid3), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Scenario A: uninterrupted pass, stray start pulses while busy / in DONE.
    $display("[TB] scenario A: free-running pass");
    applyStimulus();
    waitCycle(1);
    checkOutput("A.c1.rd_en1",    32'(rd_en1),    32'd1);
    checkOutput("A.c1.wgt_addr1", 32'(wgt_addr1), 32'd0);
    checkOutput("A.c1.in_addr1",  32'(in_addr1),  32'd0);
    checkOutput("A.c1.busy1",     32'(busy1),     32'd1);
    checkOutput("A.c1.mac_valid1", 32'(mac_valid1), 32'd0);
    waitCycle(2);
    checkOutput("A.c2.mac_valid1", 32'(mac_valid1), 32'd1);
    checkOutput("A.c2.mac_clear1", 32'(mac_clear1), 32'd1);
    waitCycle(3);
    checkOutput("A.c3.mac_valid3", 32'(mac_valid3), 32'd0);
    waitCycle(4);
    checkOutput("A.c4.mac_valid3", 32'(mac_valid3), 32'd1);
    checkOutput("A.c4.mac_clear3", 32'(mac_clear3), 32'd1);
    checkOutput("A.c4.wgt_addr3",  32'(wgt_addr3),  32'd11);
    waitCycle(5);
    checkOutput("A.c5.wgt_addr1", 32'(wgt_addr1), 32'd4);
    checkOutput("A.c5.in_addr1",  32'(in_addr1),  32'(L_IN5));
    start1 = 1'b1;
    start3 = 1'b1;
    waitCycle(6);
    start1 = 1'b0;
    start3 = 1'b0;
    waitCycle(12);
    checkOutput("A.c12.wgt_addr1", 32'(wgt_addr1), 32'd11);
    waitCycle(L_LAST1);
    checkOutput("A.last.mac_last1", 32'(mac_last1), 32'd1);
    checkOutput("A.last.nidx1",     32'(nidx1),     32'd2);
    checkOutput("A.last.done1",     32'(done1),     32'd0);
    waitCycle(L_DONE1);
    checkOutput("A.done.done1", 32'(done1), 32'd1);
    checkOutput("A.done.busy1", 32'(busy1), 32'd0);
    start1 = 1'b1;
    waitCycle(L_DONE1 + 1);
    start1 = 1'b0;
    checkOutput("A.after.done1", 32'(done1), 32'd0);
    checkOutput("A.after.busy1", 32'(busy1), 32'd0);
    checkOutput("A.pre.done3",   32'(done3), 32'd0);
    waitCycle(L_DONE3);
    checkOutput("A.done.done3", 32'(done3), 32'd1);
    start3 = 1'b1;
    waitCycle(L_DONE3 + 1);
    start3 = 1'b0;
    checkOutput("A.after.busy3", 32'(busy3), 32'd0);
    waitCycle(L_DONE3 + 3);
    checkOutput("A.idle.rd_en3", 32'(rd_en3), 32'd0);
    checkOutput("A.idle.busy1",  32'(busy1),  32'd0);

    // Scenario B: out_ready low across the first neuron boundary.
    $display("[TB] scenario B: backpressure at neuron boundary");
    applyStimulus();
    waitCycle(4);
    out_ready = 1'b0;
    waitCycle(5);
    checkOutput("B.c5.rd_en1", 32'(rd_en1), 32'(L_RD5));
    waitCycle(7);
    checkOutput("B.c7.rd_en1",    32'(rd_en1),    32'd0);
    checkOutput("B.c7.wgt_addr1", 32'(wgt_addr1), 32'(L_HOLD_WGT));
    checkOutput("B.c7.in_addr1",  32'(in_addr1),  32'd0);
    checkOutput("B.c7.busy1",     32'(busy1),     32'd1);
    out_ready = 1'b1;
    waitCycle(8);
    checkOutput("B.c8.rd_en1",    32'(rd_en1),    32'd1);
    checkOutput("B.c8.wgt_addr1", 32'(wgt_addr1), 32'(L_HOLD_WGT));
    waitCycle(L_HOLD_DONE1 - 1);
    checkOutput("B.pre.done1", 32'(done1), 32'd0);
    waitCycle(L_HOLD_DONE1);
    checkOutput("B.done.done1", 32'(done1), 32'd1);
    waitCycle(L_HOLD_DONE1 + 6);

    // Scenario C: reset in mid-pass, then a fresh pass.
    $display("[TB] scenario C: reset during a pass");
    applyStimulus();
    waitCycle(6);
    reset = 1'b1;
    waitCycle(7);
    reset = 1'b0;
    checkOutput("C.rst.rd_en1",     32'(rd_en1),     32'd0);
    checkOutput("C.rst.busy1",      32'(busy1),      32'd0);
    checkOutput("C.rst.done1",      32'(done1),      32'd0);
    checkOutput("C.rst.mac_valid1", 32'(mac_valid1), 32'd0);
    checkOutput("C.rst.wgt_addr1",  32'(wgt_addr1),  32'd0);
    checkOutput("C.rst.in_addr1",   32'(in_addr1),   32'd0);
    checkOutput("C.rst.busy3",      32'(busy3),      32'd0);
    waitCycle(10);
    checkOutput("C.idle.done1", 32'(done1), 32'd0);
    applyStimulus();
    waitCycle(L_DONE1 - 1);
    checkOutput("C.pre.done1", 32'(done1), 32'd0);
    waitCycle(L_DONE1);
    checkOutput("C.done.done1", 32'(done1), 32'd1);
    waitCycle(L_DONE3 + 3);

    // Scenario D: irregular out_ready pattern, model check only.
    $display("[TB] scenario D: irregular out_ready");
    applyStimulus();
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      out_ready = pat[c % 11];
    end
    out_ready = 1'b1;
    guard = 0;
    while ((busy1 || busy3) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("D.end.busy1", 32'(busy1), 32'd0);
    checkOutput("D.end.busy3", 32'(busy3), 32'd0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
